// File: rtl/flux_interval_capture.sv
// Measures clock counts between falling edges of the drive's RDATA flux line
// and pushes one interval word per edge (or continuation tokens) into a FIFO.
module flux_interval_capture #(
    parameter int WIDTH = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Enable,
    input  logic             i_Flux_n,
    input  logic             i_Full,
    output logic             o_Wr_DV,
    output logic [WIDTH-1:0] o_Wr_Data,
    output logic             o_Overflow,
    output logic [15:0]      o_Pulse_Count,
    output logic             o_Busy
);

    localparam logic [WIDTH-1:0] MAXV = '1;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t           r_State;
    state_t           w_Next;
    logic             r_Sync1;
    logic             r_Sync2;
    logic             r_Prev;
    logic             w_Edge;
    logic [WIDTH-1:0] r_Cnt;
    logic [WIDTH-1:0] w_Cnt_Next;
    logic [WIDTH-1:0] w_V;
    logic [WIDTH-1:0] w_Token;
    logic             w_Emit;
    logic             w_Count_Pulse;
    logic             w_Clear;

    // Two-flop synchronizer; r_Prev gives a falling-edge detect on the clean copy.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Sync1 <= 1'b1;
            r_Sync2 <= 1'b1;
            r_Prev  <= 1'b1;
        end else begin
            r_Sync1 <= i_Flux_n;
            r_Sync2 <= r_Sync1;
            r_Prev  <= r_Sync2;
        end
    end

    assign w_Edge = r_Prev & ~r_Sync2;
    assign w_V    = r_Cnt + ONE;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State <= S_IDLE;
        end else begin
            r_State <= w_Next;
        end
    end

    always_comb begin
        w_Next        = r_State;
        w_Cnt_Next    = r_Cnt;
        w_Emit        = 1'b0;
        w_Token       = w_V;
        w_Count_Pulse = 1'b0;
        w_Clear       = 1'b0;
        if (!i_Enable) begin
            w_Next     = S_IDLE;
            w_Cnt_Next = '0;
        end else begin
            case (r_State)
                S_IDLE: begin
                    w_Next     = S_ARMED;
                    w_Clear    = 1'b1;
                    w_Cnt_Next = '0;
                end
                S_ARMED: begin
                    if (w_Edge) begin
                        w_Next     = S_RUN;
                        w_Cnt_Next = '0;
                    end
                end
                S_RUN: begin
                    // An edge on the saturation cycle wins and reports MAXV as data.
                    if (w_Edge) begin
                        w_Emit        = 1'b1;
                        w_Token       = w_V;
                        w_Cnt_Next    = '0;
                        w_Count_Pulse = 1'b1;
                    end else if (w_V == MAXV) begin
                        w_Emit     = 1'b1;
                        w_Token    = '0;
                        w_Cnt_Next = '0;
                    end else begin
                        w_Cnt_Next = w_V;
                    end
                end
                default: begin
                    w_Next     = S_IDLE;
                    w_Cnt_Next = '0;
                end
            endcase
        end
    end

    // Write port: o_Wr_DV is a one-cycle push strobe with no back-pressure
    // handshake; a token decided while i_Full=1 is dropped and flagged instead.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Cnt         <= '0;
            o_Wr_DV       <= 1'b0;
            o_Wr_Data     <= '0;
            o_Overflow    <= 1'b0;
            o_Pulse_Count <= 16'd0;
        end else begin
            r_Cnt   <= w_Cnt_Next;
            o_Wr_DV <= w_Emit & ~i_Full;
            if (w_Emit && !i_Full) begin
                o_Wr_Data <= w_Token;
            end
            if (w_Clear) begin
                o_Overflow <= 1'b0;
            end else if (w_Emit && i_Full) begin
                o_Overflow <= 1'b1;
            end
            if (w_Clear) begin
                o_Pulse_Count <= 16'd0;
            end else if (w_Count_Pulse) begin
                o_Pulse_Count <= o_Pulse_Count + 16'd1;
            end
        end
    end

    assign o_Busy = (r_State != S_IDLE);

endmodule

// File: tb/tb_flux_interval_capture.sv
// Directed bench for flux_interval_capture: table of edge gaps with expected
// tokens, scoreboard queue for the write port, plus enable and reset sequences.
module tb_flux_interval_capture;

    logic       clk;
    logic       rst_l;
    logic       enable;
    logic       flux_n;
    logic       full;
    logic       wr_dv;
    logic [7:0] wr_data;
    logic       overflow;
    logic [15:0] pulse_count;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int dv_total = 0;
    int last_dv_cyc = -1;

    logic [7:0] exp_q[$];

    typedef struct {
        int         gap;
        bit         full;
        bit         lat;
        int         n;
        logic [7:0] t0;
        logic [7:0] t1;
        logic [7:0] t2;
    } vec_t;

    vec_t vecs[13];

    flux_interval_capture #(.WIDTH(8)) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_l),
        .i_Enable      (enable),
        .i_Flux_n      (flux_n),
        .i_Full        (full),
        .o_Wr_DV       (wr_dv),
        .o_Wr_Data     (wr_data),
        .o_Overflow    (overflow),
        .o_Pulse_Count (pulse_count),
        .o_Busy        (busy)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // scoreboard: every write strobe must match the head of exp_q
    always @(negedge clk) begin
        if (wr_dv === 1'b1) begin
            logic [7:0] e;
            dv_total++;
            last_dv_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL token_unexpected got=%0d required=none", wr_data);
            end else begin
                e = exp_q.pop_front();
                if (wr_data !== e) begin
                    failures++;
                    $display("FAIL token_value got=%0d required=%0d", wr_data, e);
                end
            end
        end
    end

    task automatic wait_until(input int t);
        int budget;
        budget = 0;
        while (cyc < t && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
    endtask

    task automatic drive_edge(output int c);
        flux_n = 1'b0;
        c = cyc;
        @(negedge clk);
        flux_n = 1'b1;
    endtask

    initial begin
        int   last_c;
        int   tmp_c;
        int   exp_cnt;
        int   exp_ovf;
        int   dv_snap;
        vec_t v;

        vecs[0]  = '{100, 1'b0, 1'b1, 1, 8'd100, 8'd0, 8'd0};
        vecs[1]  = '{100, 1'b0, 1'b0, 1, 8'd100, 8'd0, 8'd0};
        vecs[2]  = '{100, 1'b0, 1'b1, 1, 8'd100, 8'd0, 8'd0};
        vecs[3]  = '{600, 1'b0, 1'b1, 3, 8'd0,   8'd0, 8'd90};
        vecs[4]  = '{255, 1'b0, 1'b1, 1, 8'd255, 8'd0, 8'd0};
        vecs[5]  = '{256, 1'b0, 1'b1, 2, 8'd0,   8'd1, 8'd0};
        vecs[6]  = '{50,  1'b0, 1'b0, 1, 8'd50,  8'd0, 8'd0};
        vecs[7]  = '{50,  1'b1, 1'b0, 0, 8'd0,   8'd0, 8'd0};
        vecs[8]  = '{50,  1'b0, 1'b1, 1, 8'd50,  8'd0, 8'd0};
        vecs[9]  = '{50,  1'b0, 1'b0, 1, 8'd50,  8'd0, 8'd0};
        vecs[10] = '{2,   1'b0, 1'b0, 1, 8'd2,   8'd0, 8'd0};
        vecs[11] = '{3,   1'b0, 1'b0, 1, 8'd3,   8'd0, 8'd0};
        vecs[12] = '{40,  1'b0, 1'b1, 1, 8'd40,  8'd0, 8'd0};

        rst_l  = 1'b0;
        enable = 1'b0;
        flux_n = 1'b1;
        full   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_dv", wr_dv, 0);
        chk("reset_data", wr_data, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_count", pulse_count, 0);
        chk("reset_busy", busy, 0);
        rst_l = 1'b1;
        @(negedge clk);

        // enabled with no flux: armed, silent
        enable = 1'b1;
        repeat (1000) @(negedge clk);
        chk("armed_no_dv", dv_total, 0);
        chk("armed_busy", busy, 1);
        chk("armed_count", pulse_count, 0);

        drive_edge(last_c);
        exp_cnt = 0;
        exp_ovf = 0;

        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            if (v.n > 0) exp_q.push_back(v.t0);
            if (v.n > 1) exp_q.push_back(v.t1);
            if (v.n > 2) exp_q.push_back(v.t2);
            wait_until(last_c + v.gap);
            if (v.full) full = 1'b1;
            drive_edge(last_c);
            exp_cnt++;
            if (v.full) begin
                exp_ovf = 1;
                repeat (2) @(negedge clk);
                full = 1'b0;
            end
            if (v.lat) begin
                wait_until(last_c + 4);
                chk("edge_latency", last_dv_cyc, last_c + 3);
                chk("pulse_count", pulse_count, exp_cnt);
                chk("overflow", overflow, exp_ovf);
            end
        end

        // enable drop mid-interval: no partial token, overflow clears on re-enable
        wait_until(last_c + 40);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("disabled_busy", busy, 0);
        chk("disabled_overflow_sticky", overflow, 1);
        drive_edge(tmp_c);
        repeat (5) @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("reenable_busy", busy, 1);
        chk("reenable_overflow", overflow, 0);
        chk("reenable_count", pulse_count, 0);
        repeat (300) @(negedge clk);
        drive_edge(last_c);
        exp_q.push_back(8'd70);
        wait_until(last_c + 70);
        drive_edge(last_c);
        wait_until(last_c + 4);
        chk("rearm_latency", last_dv_cyc, last_c + 3);
        chk("rearm_count", pulse_count, 1);

        // asynchronous reset mid-RUN
        repeat (20) @(negedge clk);
        dv_snap = dv_total;
        #2 rst_l = 1'b0;
        #1;
        chk("async_rst_dv", wr_dv, 0);
        chk("async_rst_data", wr_data, 0);
        chk("async_rst_overflow", overflow, 0);
        chk("async_rst_count", pulse_count, 0);
        chk("async_rst_busy", busy, 0);
        @(negedge clk);
        rst_l = 1'b1;
        repeat (300) @(negedge clk);
        chk("post_rst_busy", busy, 1);
        chk("post_rst_no_dv", dv_total, dv_snap);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
